dcmac_rx_pad_strip: RTL
=======================

Name: dcmac_rx_pad_strip

Overview:
- Receive-side companion to the DCMAC TX pad stage, on the 1024-bit AXI-stream path between the DCMAC RX client and the Ethernet/IPv4/UDP/RoCE parser.
- DCMAC delivers frames with FCS already stripped, so the minimum legal frame is 60 bytes.
- For IPv4 frames that carry Ethernet pad bytes, the block trims tkeep to the true L3 length (14 + IPv4 total length) and zeroes the pad bytes.
- It flags runt and truncated frames on tuser and emits per-frame status pulses; it never drops beats.

Parameters:
- DATA_WIDTH, 1024, AXI-stream data width; only 1024 is supported (elaboration error otherwise).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width; must satisfy KEEP_WIDTH*8 == DATA_WIDTH.
- USER_WIDTH, 1, tuser width; bit 0 is the bad-frame flag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  input data; byte k is tdata[8k+7:8k]; byte 0 is the first on the wire.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables; contiguous from bit 0.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of frame.
- s_axis_tuser  in  USER_WIDTH  input bad-frame flag from the MAC.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of frame.
- m_axis_tuser  out  USER_WIDTH  output bad-frame flag.
- stat_pad_stripped  out  1  one-cycle pulse when a frame had pad removed.
- stat_len_err  out  1  one-cycle pulse when a frame was flagged runt or truncated.

Behaviour:
- Latency is exactly one registered stage. Accept = s_axis_tvalid && s_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready. This gives full throughput with no bubbles when the sink is always ready.
- Output register: loads on accept. Otherwise m_axis_tvalid clears when m_axis_tready is high; the output holds stable while tvalid && !tready.
- Reset values: all outputs 0 (tvalid, tlast, tkeep, tdata, tuser, both stat pulses); frame state = FIRST; byte counter = 0.
- Frame state, two states:
  - FIRST: next beat is the start of a frame.
  - BODY: mid-frame.
  - FIRST -> BODY on accept with !tlast. BODY -> FIRST on accept with tlast. FIRST with tlast stays in FIRST.
- Beat byte count n = index of the highest set tkeep bit + 1 (0..128).
- byte_cnt is 16-bit and saturates at 0xFFFF. It is loaded with n on the first beat and accumulates n on later beats. The total used at tlast includes the current beat.
- First-beat decode, latched for the whole frame:
  - is_ipv4 = (byte12, byte13) == 0x08, 0x00. VLAN-tagged frames are not IPv4 for this block.
  - exp_len = 14 + {byte16, byte17}, 17-bit.
  - If n < 18 on the first beat, is_ipv4 = 0.
- Pad strip applies only on a single-beat frame (first beat with tlast) where is_ipv4, 34 <= exp_len < n, and n <= 60.
  - Output tkeep = low exp_len bits set; data bytes at index >= exp_len are driven 0.
  - stat_pad_stripped pulses when that beat is loaded.
- Frames with total > 60 and total > exp_len pass unmodified with no error (trailer permitted).
- Length errors, evaluated on the tlast beat:
  - runt: total < 60.
  - truncated: is_ipv4 and total < exp_len.
  - m_axis_tuser[0] = s_axis_tuser[0] | runt | truncated on the tlast beat. Non-last beats pass s_axis_tuser through.
  - stat_len_err pulses when a tlast beat with runt | truncated is loaded.
- Bytes with tkeep = 0 are output as 0 on every beat.
- Stat pulses are high for exactly one clk, coincident with the load into the output register, regardless of m_axis_tready.
- Asynchronous reset mid-frame: the output beat is discarded and state returns to FIRST. The next accepted beat is decoded as a frame start; the remainder of the interrupted frame is treated as a new frame.

Test Plan:
- 42-byte IPv4 frame padded to n=60 with total length 28: out tkeep = 0x3FF_FFFF_FFFF (42 bits), bytes 42..59 zero, tuser=0, stat_pad_stripped=1.
- 300-byte IPv4 frame over 3 beats (128, 128, 44) with total length 286: passed unchanged, tlast on the 3rd beat, tuser=0, no stat pulses.
- 200-byte IPv4 frame (128 + 72) with total length 1000: 2nd beat tuser=1, stat_len_err=1, tkeep untouched.
- 50-byte non-IPv4 frame (ethertype 0x86DD) with tlast: tuser=1 (runt), stat_len_err=1, no trim.
- Back-to-back single-beat frames with m_axis_tready toggling 1,0,0,1: no beat lost or duplicated, outputs stable while stalled, s_axis_tready low only while stalled with output full.
- Assert rst during the 2nd beat of a 3-beat frame, then release and send a 60-byte IPv4 frame: all outputs 0 during reset; the new frame is decoded as FIRST and stripped correctly.

Source files
------------

// File: rtl/dcmac_rx_pad_strip.sv
// dcmac_rx_pad_strip
//   Receive-side pad stripper on the 1024-bit DCMAC RX AXI-stream path.
//   Single-beat IPv4 frames carrying Ethernet pad have tkeep trimmed to
//   14 + IPv4 total length and the pad bytes zeroed. Runt (< 60 bytes) and
//   truncated (shorter than the IPv4 length) frames are flagged on tuser[0]
//   on their last beat. Beats are never dropped; latency is one register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_axis_*                 input stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*                 output stream, same fields
//   stat_pad_stripped        one-cycle pulse when a frame had pad removed
//   stat_len_err             one-cycle pulse when a frame was flagged runt/truncated
module dcmac_rx_pad_strip #(
  parameter int DATA_WIDTH = 1024,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  stat_pad_stripped,
  output logic                  stat_len_err
);

  if (DATA_WIDTH != 1024 || KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
    $error("dcmac_rx_pad_strip supports only DATA_WIDTH=1024 with KEEP_WIDTH=DATA_WIDTH/8");
  end

  typedef enum logic {ST_FIRST, ST_BODY} state_t;

  state_t state_q, state_d;

  logic [15:0] byte_cnt_q;
  logic        frame_ipv4_q;
  logic [16:0] frame_exp_q;

  logic                  accept;
  logic                  first;
  logic [7:0]            beat_n;
  logic                  hdr_ipv4;
  logic [16:0]           hdr_exp;
  logic                  cur_ipv4;
  logic [16:0]           cur_exp;
  logic [16:0]           sum;
  logic [15:0]           total;
  logic                  runt;
  logic                  trunc;
  logic                  strip;
  logic [KEEP_WIDTH-1:0] keep_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [USER_WIDTH-1:0] user_d;
  logic                  len_err_d;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign first         = (state_q == ST_FIRST);

  // Beat byte count: highest set tkeep bit + 1.
  always_comb begin
    beat_n = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i]) beat_n = 8'(i + 1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FIRST;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) state_d = s_axis_tlast ? ST_FIRST : ST_BODY;
  end

  // Output/datapath logic for the beat being offered
  always_comb begin
    hdr_ipv4 = (beat_n >= 8'd18) && (s_axis_tdata[103:96] == 8'h08) &&
               (s_axis_tdata[111:104] == 8'h00);
    hdr_exp  = 17'd14 + {1'b0, s_axis_tdata[135:128], s_axis_tdata[143:136]};

    // Header fields come straight from the bus on a first beat, from the
    // latched copy afterwards.
    cur_ipv4 = first ? hdr_ipv4 : frame_ipv4_q;
    cur_exp  = first ? hdr_exp  : frame_exp_q;

    sum   = {1'b0, byte_cnt_q} + {9'd0, beat_n};
    if (first)        total = {8'd0, beat_n};
    else if (sum[16]) total = 16'hFFFF;
    else              total = sum[15:0];

    runt  = total < 16'd60;
    trunc = cur_ipv4 && ({1'b0, total} < cur_exp);
    strip = first && s_axis_tlast && hdr_ipv4 && (hdr_exp >= 17'd34) &&
            (hdr_exp < {9'd0, beat_n}) && (beat_n <= 8'd60);

    keep_d = s_axis_tkeep;
    if (strip) begin
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) keep_d[i] = (17'(i) < hdr_exp);
    end

    data_d = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      if (keep_d[i]) data_d[8*i +: 8] = s_axis_tdata[8*i +: 8];
    end

    user_d = s_axis_tuser;
    if (s_axis_tlast) user_d[0] = s_axis_tuser[0] | runt | trunc;

    len_err_d = s_axis_tlast && (runt || trunc);
  end

  // Per-frame context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      frame_ipv4_q <= 1'b0;
      frame_exp_q  <= '0;
    end else if (accept) begin
      byte_cnt_q <= total;
      if (first) begin
        frame_ipv4_q <= hdr_ipv4;
        frame_exp_q  <= hdr_exp;
      end
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= '0;
      stat_pad_stripped <= 1'b0;
      stat_len_err      <= 1'b0;
    end else begin
      stat_pad_stripped <= 1'b0;
      stat_len_err      <= 1'b0;
      if (accept) begin
        m_axis_tdata      <= data_d;
        m_axis_tkeep      <= keep_d;
        m_axis_tvalid     <= 1'b1;
        m_axis_tlast      <= s_axis_tlast;
        m_axis_tuser      <= user_d;
        stat_pad_stripped <= strip;
        stat_len_err      <= len_err_d;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
